bitstream_seq_ctrl: RTL and testbench
=====================================

// Module: bitstream_seq_ctrl
// PURPOSE
//  Sequencing controller for a serial pattern detector (Moore, one bit per clock).
//  Accepts parallel words over valid/ready and shifts each word MSB-first into the detector,
//  gating the detector with det_en. Samples the detector's Moore output one cycle after each bit,
//  then returns a per-word match count and the position of the first match over valid/ready.
//  Sits between a word source (bus/FIFO) and the detector.
// PARAMETERS
//  WORD_W          16  bits per word; >= 2
//  CLEAR_EACH_WORD 1   1: pulse det_clr before every word; 0: detector state carries across words
//  localparam CNT_W = $clog2(WORD_W+1)   width of count/position fields
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       word available
//  in_ready   out  1       controller can accept (high only in IDLE)
//  in_word    in   WORD_W  word to serialise; bit WORD_W-1 goes first
//  abort      in   1       sync; drop current word, return to IDLE
//  det_clr    out  1       1-cycle sync clear to detector (state -> start state)
//  det_en     out  1       detector advances on this edge
//  det_bit    out  1       serial bit to detector, valid while det_en=1
//  det_z      in   1       detector Moore output (state-decoded, registered state)
//  out_valid  out  1       result valid; held until out_ready
//  out_ready  in   1       result consumer ready
//  match_cnt  out  CNT_W   number of det_z=1 samples for this word
//  first_pos  out  CNT_W   1-based bit index of first match; 0 = no match
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid, det_clr, det_en, det_bit, busy = 0;
//    match_cnt, first_pos, shift reg, bit counter = 0. Reset mid-word discards the word.
//  FSM: IDLE -> CLR -> SHIFT -> DRAIN -> DONE -> IDLE.
//   IDLE : in_ready=1. in_valid & in_ready at edge E0 -> capture in_word;
//          clear cnt/first_pos -> CLR.
//   CLR  : one cycle always. det_clr = CLEAR_EACH_WORD. det_en=0. -> SHIFT.
//   SHIFT: WORD_W cycles. det_en=1, det_bit=shreg[WORD_W-1]; shreg shifts left each edge;
//          bit counter 1..WORD_W. After the WORD_W-th bit -> DRAIN.
//   DRAIN: one cycle. Samples z of the last bit. -> DONE.
//   DONE : out_valid=1, outputs stable. out_valid & out_ready -> IDLE (out_valid=0 next cycle).
//  det_en/det_bit are decoded from registers only (no input-to-output comb path).
//  Sampling: pend <= det_en, pend_pos <= bit index. Each cycle with pend=1 and det_z=1:
//    match_cnt+1; if first_pos==0 then first_pos <= pend_pos. det_z ignored when pend=0.
//  Latency: out_valid rises WORD_W+2 edges after accepting edge E0 (18 for WORD_W=16).
//  Next word accepted the edge after result handshake.
//  Worst-case throughput: WORD_W+4 cycles/word.
//  match_cnt cannot overflow (<= WORD_W by construction); no saturation logic needed.
//  abort=1 in CLR/SHIFT/DRAIN/DONE: next state IDLE.
//    Result is discarded (out_valid=0 next cycle, never handshaken).
//    det_en=0 from the next cycle; det_clr pulses for 1 cycle in IDLE if CLEAR_EACH_WORD=1.
//  abort=1 in IDLE: ignored. A word handshake in the same cycle is accepted.
//  abort and out_ready both high in DONE: abort wins; the result is not counted as delivered.
//  in_word is captured only at the handshake. Later changes to in_word have no effect.
// STRUCTURE
//  Single module. FSM encoding, CNT_W formula and state localparams live in the shared
//  seq_det_pkg, so the detector and bench use the same definitions.
//  Natural sub-module: piso_shreg (WORD_W load/shift-left register with bit counter).
//  The detector is external; the bench detector model is Moore 1-0-0-1:
//    extra 0s hold in the "100" state; a 1 from the match state restarts at "1";
//    a 0 from the match state goes to "10". Has det_en gating and det_clr.
// TESTING
//  1. WORD_W=16, CLEAR=1, word 16'h899D -> match_cnt=3, first_pos=5;
//     out_valid exactly 18 edges after accept.
//  2. word 16'h9249 -> match_cnt=5, first_pos=4; word 16'h0000 and 16'hFFFF -> cnt=0, pos=0.
//  3. CLEAR=0: 16'h0008 then 16'h8000 -> results (0,0) then (1,1);
//     same pair with CLEAR=1 -> (0,0), (0,0).
//  4. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//     Outputs must stay stable, in_ready=0, det_en=0; then handshake -> in_ready=1 next cycle.
//  5. abort at SHIFT bit 7 of 16'h899D -> IDLE next edge, no out_valid, det_clr pulse.
//     Resend 16'h899D -> (3,5).
//  6. rst_n low mid-SHIFT (async, between edges) -> all outputs at reset values immediately;
//     after release, 16'h9249 -> (5,4).

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector controller and its users.
package seq_det_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  localparam int unsigned DEFAULT_WORD_W = 16;

  // Width of the count/position fields: must hold values 0..word_w.
  function automatic int unsigned cnt_width(input int unsigned word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/bitstream_seq_ctrl_piso_shreg.sv
// Parallel-in serial-out shift register (MSB first) with a count of bits shifted.
module piso_shreg #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              msb,
  output logic [CNT_W-1:0]  cnt,
  output logic              last
);

  logic [WORD_W-1:0] shreg;

  // Load a new word (count restarts) or shift left one bit per enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= din;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= {shreg[WORD_W-2:0], 1'b0};
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign msb  = shreg[WORD_W-1];
  // High while the final bit of the word is being presented.
  assign last = (cnt == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/bitstream_seq_ctrl.sv
// Sequencing controller: serialises words into an external Moore detector and
// returns the per-word match count and first match position.
module bitstream_seq_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned WORD_W          = DEFAULT_WORD_W,
  parameter bit          CLEAR_EACH_WORD = 1'b1,
  localparam int unsigned CNT_W          = cnt_width(WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              abort,
  output logic              det_clr,
  output logic              det_en,
  output logic              det_bit,
  input  logic              det_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  first_pos,
  output logic              busy
);

  seq_state_t       state, next_state;
  logic             accept;
  logic             shift_msb;
  logic             shift_last;
  logic [CNT_W-1:0] bit_cnt;
  logic             pend;
  logic [CNT_W-1:0] pend_pos;
  logic             abort_clr;

  assign accept = in_valid & in_ready;

  piso_shreg #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (state == ST_SHIFT),
    .din   (in_word),
    .msb   (shift_msb),
    .cnt   (bit_cnt),
    .last  (shift_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and register-decoded outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    det_en     = 1'b0;
    det_bit    = 1'b0;
    det_clr    = CLEAR_EACH_WORD & abort_clr;
    out_valid  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) next_state = ST_CLR;
      end
      ST_CLR: begin
        det_clr    = CLEAR_EACH_WORD;
        next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        det_en  = 1'b1;
        det_bit = shift_msb;
        if (shift_last) next_state = ST_DRAIN;
      end
      ST_DRAIN: next_state = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    // Abort outranks every other transition, including a result handshake.
    if (abort && state != ST_IDLE) next_state = ST_IDLE;
  end

  // Sample the detector output one cycle after each bit and accumulate results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_pos  <= '0;
      match_cnt <= '0;
      first_pos <= '0;
      abort_clr <= 1'b0;
    end else begin
      // An aborted bit is never sampled, so the result fields stay quiet in IDLE.
      pend      <= det_en & ~abort;
      pend_pos  <= bit_cnt + CNT_W'(1);
      abort_clr <= abort & (state != ST_IDLE);
      if (accept) begin
        match_cnt <= '0;
        first_pos <= '0;
      end else if (pend && det_z) begin
        match_cnt <= match_cnt + CNT_W'(1);
        if (first_pos == '0) first_pos <= pend_pos;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_seq_ctrl.sv
// Directed bench for bitstream_seq_ctrl with a 1-0-0-1 Moore detector model
// and a result scoreboard; one instance per CLEAR_EACH_WORD setting.
module tb_bitstream_seq_ctrl;
  import seq_det_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = cnt_width(W);

  typedef struct {
    logic [CW-1:0] cnt;
    logic [CW-1:0] pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, abort, out_ready, sel;
  logic [W-1:0] in_word;

  // Instance a: CLEAR_EACH_WORD=1, instance b: CLEAR_EACH_WORD=0.
  logic          in_ready_a, det_clr_a, det_en_a, det_bit_a, det_z_a, out_valid_a, busy_a;
  logic          in_ready_b, det_clr_b, det_en_b, det_bit_b, det_z_b, out_valid_b, busy_b;
  logic [CW-1:0] match_cnt_a, first_pos_a, match_cnt_b, first_pos_b;
  logic [2:0]    ds_a, ds_b;

  // View of the instance selected by sel.
  logic          in_ready, det_clr, det_en, det_bit, out_valid, busy;
  logic [CW-1:0] match_cnt, first_pos;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  bitstream_seq_ctrl #(.WORD_W(W), .CLEAR_EACH_WORD(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready_a),
    .in_word(in_word), .abort(abort & ~sel), .det_clr(det_clr_a), .det_en(det_en_a),
    .det_bit(det_bit_a), .det_z(det_z_a), .out_valid(out_valid_a),
    .out_ready(out_ready & ~sel), .match_cnt(match_cnt_a), .first_pos(first_pos_a),
    .busy(busy_a)
  );

  bitstream_seq_ctrl #(.WORD_W(W), .CLEAR_EACH_WORD(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready_b),
    .in_word(in_word), .abort(abort & sel), .det_clr(det_clr_b), .det_en(det_en_b),
    .det_bit(det_bit_b), .det_z(det_z_b), .out_valid(out_valid_b),
    .out_ready(out_ready & sel), .match_cnt(match_cnt_b), .first_pos(first_pos_b),
    .busy(busy_b)
  );

  assign in_ready  = sel ? in_ready_b  : in_ready_a;
  assign det_clr   = sel ? det_clr_b   : det_clr_a;
  assign det_en    = sel ? det_en_b    : det_en_a;
  assign det_bit   = sel ? det_bit_b   : det_bit_a;
  assign out_valid = sel ? out_valid_b : out_valid_a;
  assign busy      = sel ? busy_b      : busy_a;
  assign match_cnt = sel ? match_cnt_b : match_cnt_a;
  assign first_pos = sel ? first_pos_b : first_pos_a;

  // Detector 1-0-0-1: 0=start, 1="1", 2="10", 3="100", 4=match.
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd1 : 3'd2;
      3'd2:    return b ? 3'd1 : 3'd3;
      3'd3:    return b ? 3'd4 : 3'd3;
      default: return b ? 3'd1 : 3'd2;
    endcase
  endfunction

  // Detector models driving each instance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ds_a <= 3'd0;
    else if (det_clr_a) ds_a <= 3'd0;
    else if (det_en_a)  ds_a <= det_next(ds_a, det_bit_a);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ds_b <= 3'd0;
    else if (det_clr_b) ds_b <= 3'd0;
    else if (det_en_b)  ds_b <= det_next(ds_b, det_bit_b);
  end
  assign det_z_a = (ds_a == 3'd4);
  assign det_z_b = (ds_b == 3'd4);

  // Reference result for a word run from the detector start state.
  function automatic exp_t ref_word(input logic [W-1:0] w);
    exp_t r;
    logic [2:0] s;
    s     = 3'd0;
    r.cnt = '0;
    r.pos = '0;
    for (int i = W - 1; i >= 0; i--) begin
      s = det_next(s, w[i]);
      if (s == 3'd4) begin
        r.cnt = r.cnt + CW'(1);
        if (r.pos == '0) r.pos = CW'(W - i);
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offer a word and complete its handshake; optionally record the expected result.
  task automatic send(input logic [W-1:0] w, input bit push, input exp_t e, input bit abort_idle);
    int unsigned n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    abort    = abort_idle;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    in_word  = W'($urandom);
    if (push) sb.push_back(e);
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_det_clr", 32'(det_clr), sel ? 32'd0 : 32'd1);
    check("clr_det_en", 32'(det_en), 32'd0);
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then handshake.
  task automatic receive(input int unsigned hold);
    int unsigned lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, W + 2);
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("match_cnt", 32'(match_cnt), 32'(e.cnt));
      check("first_pos", 32'(first_pos), 32'(e.pos));
      for (int unsigned i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_match_cnt", 32'(match_cnt), 32'(e.cnt));
        check("hold_first_pos", 32'(first_pos), 32'(e.pos));
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_det_en", 32'(det_en), 32'd0);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic exp_t mk(input int unsigned c, input int unsigned p);
    exp_t r;
    r.cnt = CW'(c);
    r.pos = CW'(p);
    return r;
  endfunction

  initial begin
    logic [W-1:0] rw;
    int unsigned seen;
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; sel = 1'b0; in_word = '0;

    // Reset values.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_det_en", 32'(det_en), 32'd0);
    check("rst_det_clr", 32'(det_clr), 32'd0);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known words.
    send(16'h899D, 1'b1, mk(3, 5), 1'b0);  receive(0);
    send(16'h9249, 1'b1, mk(5, 4), 1'b0);  receive(0);
    send(16'h0000, 1'b1, mk(0, 0), 1'b0);  receive(0);
    send(16'hFFFF, 1'b1, mk(0, 0), 1'b0);  receive(0);

    // Backpressure in DONE.
    send(16'h899D, 1'b1, mk(3, 5), 1'b0);  receive(10);

    // Random words; one accepted while abort is held in IDLE.
    for (int i = 0; i < 4; i++) begin
      rw = W'($urandom);
      send(rw, 1'b1, ref_word(rw), i == 2);
      receive(0);
    end

    // Detector state carried across words versus cleared per word.
    sel = 1'b1;
    send(16'h0008, 1'b1, mk(0, 0), 1'b0);  receive(0);
    send(16'h8000, 1'b1, mk(1, 1), 1'b0);  receive(0);
    sel = 1'b0;
    send(16'h0008, 1'b1, mk(0, 0), 1'b0);  receive(0);
    send(16'h8000, 1'b1, mk(0, 0), 1'b0);  receive(0);

    // Abort while bit 7 is presented.
    send(16'h899D, 1'b0, mk(0, 0), 1'b0);
    repeat (7) @(posedge clk);
    #1;
    check("pre_abort_det_en", 32'(det_en), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_det_en", 32'(det_en), 32'd0);
    check("abort_det_clr", 32'(det_clr), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("abort_det_clr_end", 32'(det_clr), 32'd0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 32'd0);
    send(16'h899D, 1'b1, mk(3, 5), 1'b0);  receive(0);

    // Asynchronous reset mid-SHIFT.
    send(16'h9249, 1'b0, mk(0, 0), 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_det_en", 32'(det_en), 32'd0);
    check("arst_det_bit", 32'(det_bit), 32'd0);
    check("arst_det_clr", 32'(det_clr), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_match_cnt", 32'(match_cnt), 32'd0);
    check("arst_first_pos", 32'(first_pos), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(16'h9249, 1'b1, mk(5, 4), 1'b0);  receive(0);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
